data_sram_confreg: RTL and testbench

Memory-mapped configuration-register responder on the data SRAM interface. It is the target side of the core's `data_sram_*` port. It decodes one access per cycle, applies byte-enabled writes, and returns registered read data one cycle later. It holds the board-visible LED and number registers, a switch input, a scratch register, and a free-running timer with a compare interrupt. It sits in the SoC top beside the data RAM and answers only addresses inside its window.

---
 rtl/data_sram_confreg_if.sv | 12 +
 rtl/data_sram_confreg.sv | 156 +++++++++++++++
 tb/tb_data_sram_confreg.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_confreg_if.sv
// Data SRAM access port between the core (master) and a memory-mapped target (slave).
// One access per cycle; rdata is registered by the target and valid one cycle later.
interface data_sram_confreg_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, wen, addr, wdata, input rdata);
    modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_confreg.sv
// Configuration-register responder on the data SRAM port: LED, NUM, SWITCH, SCRATCH,
// and a free-running TIMER with a sticky COMPARE-match interrupt. Read data is registered.
module data_sram_confreg #(
    parameter logic [31:0] BASE = 32'hBFAF_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    data_sram_confreg_if.slave        bus,
    input  logic [7:0]                switch,
    output logic [15:0]               led,
    output logic [31:0]               num_data,
    output logic                      timer_int
);

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_NUM     = 16'hF004;
    localparam logic [15:0] OFF_SWITCH  = 16'hF008;
    localparam logic [15:0] OFF_SCRATCH = 16'hF010;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_COMPARE = 16'hE004;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED,
        SEL_NUM,
        SEL_SWITCH,
        SEL_SCRATCH,
        SEL_TIMER,
        SEL_COMPARE
    } reg_sel_e;

    reg_sel_e    sel;
    logic [15:0] offset;
    logic        in_window;
    logic        is_write;
    logic [31:0] read_val;
    logic [31:0] wr_merged;

    logic [31:0] num_q;
    logic [31:0] scratch_q;
    logic [31:0] timer_q;
    logic [31:0] compare_q;
    logic [7:0]  switch_meta;
    logic [7:0]  switch_sync;

    // Byte-lane merge of write data over the register's current contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

    assign offset    = bus.addr[15:0] & 16'hFFFC;
    assign in_window = (bus.addr[31:16] == BASE[31:16]);
    assign is_write  = bus.en && (bus.wen != 4'b0000);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel = SEL_NONE;
        if (in_window) begin
            case (offset)
                OFF_LED:     sel = SEL_LED;
                OFF_NUM:     sel = SEL_NUM;
                OFF_SWITCH:  sel = SEL_SWITCH;
                OFF_SCRATCH: sel = SEL_SCRATCH;
                OFF_TIMER:   sel = SEL_TIMER;
                OFF_COMPARE: sel = SEL_COMPARE;
                default:     sel = SEL_NONE;
            endcase
        end
    end

    // Pre-edge value of the addressed register; unmapped and out-of-window read as zero.
    always_comb begin
        read_val = 32'h0;
        case (sel)
            SEL_LED:     read_val = {16'h0, led};
            SEL_NUM:     read_val = num_q;
            SEL_SWITCH:  read_val = {24'h0, switch_sync};
            SEL_SCRATCH: read_val = scratch_q;
            SEL_TIMER:   read_val = timer_q;
            SEL_COMPARE: read_val = compare_q;
            default:     read_val = 32'h0;
        endcase
    end

    assign wr_merged = merge_bytes(read_val, bus.wdata, bus.wen);

    // Read-during-write returns the old value because read_val is sampled pre-edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of block ordering.
        if (rst) begin
            bus.rdata <= 32'h0;
        end else if (bus.en) begin
            bus.rdata <= read_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led       <= 16'h0;
            num_q     <= 32'h0;
            scratch_q <= 32'h0;
            compare_q <= 32'hFFFF_FFFF;
        end else if (is_write) begin
            case (sel)
                SEL_LED:     led       <= wr_merged[15:0];
                SEL_NUM:     num_q     <= wr_merged;
                SEL_SCRATCH: scratch_q <= wr_merged;
                SEL_COMPARE: compare_q <= wr_merged;
                default:     ;
            endcase
        end
    end

    assign num_data = num_q;

    // A TIMER write replaces that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= 32'h0;
        end else if (is_write && (sel == SEL_TIMER)) begin
            timer_q <= wr_merged;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Clear on any COMPARE write takes priority over a coincident match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_int <= 1'b0;
        end else if (is_write && (sel == SEL_COMPARE)) begin
            timer_int <= 1'b0;
        end else if (timer_q == compare_q) begin
            timer_int <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            switch_meta <= 8'h0;
            switch_sync <= 8'h0;
        end else begin
            switch_meta <= switch;
            switch_sync <= switch_meta;
        end
    end

endmodule

// File: tb/tb_data_sram_confreg.sv
// Self-checking bench for data_sram_confreg: directed register-map scenarios followed by
// randomized traffic, all compared against a transaction-level register model.
module tb_data_sram_confreg;

    localparam logic [31:0] BASE      = 32'hBFAF_0000;
    localparam logic [31:0] A_LED     = 32'hBFAF_F000;
    localparam logic [31:0] A_NUM     = 32'hBFAF_F004;
    localparam logic [31:0] A_SWITCH  = 32'hBFAF_F008;
    localparam logic [31:0] A_UNMAP   = 32'hBFAF_F00C;
    localparam logic [31:0] A_SCRATCH = 32'hBFAF_F010;
    localparam logic [31:0] A_TIMER   = 32'hBFAF_E000;
    localparam logic [31:0] A_COMPARE = 32'hBFAF_E004;
    localparam logic [31:0] A_OUTSIDE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_int;

    data_sram_confreg_if bus ();

    data_sram_confreg #(.BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .switch    (switch),
        .led       (led),
        .num_data  (num_data),
        .timer_int (timer_int)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Register model, indexed by word offset within the window.
    logic [31:0] m_regs [logic [15:0]];
    logic [31:0] m_rdata;
    logic        m_int;
    logic [7:0]  sw_seen [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_regs.delete();
        m_regs[16'hF000] = 32'h0;
        m_regs[16'hF004] = 32'h0;
        m_regs[16'hF010] = 32'h0;
        m_regs[16'hE000] = 32'h0;
        m_regs[16'hE004] = 32'hFFFF_FFFF;
        m_rdata = 32'h0;
        m_int   = 1'b0;
        sw_seen.delete();
    endtask

    // Switch as seen by a read: the value sampled two edges earlier.
    function automatic logic [31:0] model_switch();
        if (sw_seen.size() < 2) return 32'h0;
        return {24'h0, sw_seen[sw_seen.size() - 2]};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [15:0] off;
        off = a[15:0] & 16'hFFFC;
        if (a[31:16] != BASE[31:16]) return 32'h0;
        if (off == 16'hF008) return model_switch();
        if (m_regs.exists(off)) return m_regs[off];
        return 32'h0;
    endfunction

    // Apply one clock edge's worth of architectural effects.
    task automatic model_edge(input logic en, input logic [3:0] wen,
                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] old_val, merged;
        logic [15:0] off;
        logic        hit_wr, match;
        off     = a[15:0] & 16'hFFFC;
        old_val = model_read(a);
        hit_wr  = en && (wen != 4'b0) && (a[31:16] == BASE[31:16]);
        match   = (m_regs[16'hE000] == m_regs[16'hE004]);
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = wen[i] ? d[8*i +: 8] : old_val[8*i +: 8];
        if (en) m_rdata = old_val;
        m_regs[16'hE000] = m_regs[16'hE000] + 32'd1;
        if (hit_wr) begin
            if (off == 16'hF000) m_regs[off] = {16'h0, merged[15:0]};
            else if (off == 16'hF004 || off == 16'hF010 || off == 16'hE000 || off == 16'hE004)
                m_regs[off] = merged;
        end
        if (hit_wr && off == 16'hE004) m_int = 1'b0;
        else if (match)                m_int = 1'b1;
        sw_seen.push_back(switch);
        if (sw_seen.size() > 4) void'(sw_seen.pop_front());
    endtask

    task automatic cycle(input logic en, input logic [3:0] wen,
                         input logic [31:0] a, input logic [31:0] d);
        bus.en    = en;
        bus.wen   = wen;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        model_edge(en, wen, a, d);
        #1;
        check("rdata",     bus.rdata,              m_rdata);
        check("led",       {16'h0, led},           m_regs[16'hF000]);
        check("num_data",  num_data,               m_regs[16'hF004]);
        check("timer_int", {31'h0, timer_int},     {31'h0, m_int});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wen = 4'hF);
        cycle(1'b1, wen, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic idle();
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Reset asserted and released between clock edges.
    task automatic mid_cycle_reset();
        #2 rst = 1'b1;
        bus.en = 1'b0;
        #1;
        model_reset();
        check("rst_led",   {16'h0, led},        32'h0);
        check("rst_num",   num_data,            32'h0);
        check("rst_rdata", bus.rdata,           32'h0);
        check("rst_int",   {31'h0, timer_int},  32'h0);
        #1 rst = 1'b0;
    endtask

    logic [31:0] addr_tbl [9];
    int          edges_to_int;

    initial begin
        addr_tbl = '{A_LED, A_NUM, A_SWITCH, A_UNMAP, A_SCRATCH,
                     A_TIMER, A_COMPARE, A_OUTSIDE, 32'hBFAF_1234};
        rst = 1'b1;
        switch = 8'h00;
        bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
        model_reset();
        #12;
        check("init_led",   {16'h0, led},       32'h0);
        check("init_rdata", bus.rdata,          32'h0);
        check("init_int",   {31'h0, timer_int}, 32'h0);
        rst = 1'b0;

        rd(A_COMPARE);
        check("compare_reset", bus.rdata, 32'hFFFF_FFFF);

        // Byte-enabled write into NUM.
        wr(A_NUM, 32'h1234_5678);
        wr(A_NUM, 32'hAABB_CCDD, 4'b0101);
        rd(A_NUM);
        check("num_bytes_rd",  bus.rdata, 32'h12BB_56DD);
        check("num_bytes_out", num_data,  32'h12BB_56DD);

        // LED width and unmapped/out-of-window accesses.
        wr(A_LED, 32'hFFFF_FFFF);
        check("led_out", {16'h0, led}, 32'h0000_FFFF);
        rd(A_LED);
        check("led_rd", bus.rdata, 32'h0000_FFFF);
        wr(A_UNMAP, 32'hDEAD_BEEF);
        rd(A_UNMAP);
        check("unmapped_rd", bus.rdata, 32'h0);
        wr(A_OUTSIDE, 32'hCAFE_F00D);
        rd(A_OUTSIDE);
        check("outside_rd", bus.rdata, 32'h0);

        // Timer compare: TIMER=10 then COMPARE=20 leaves 10 edges until the match edge.
        wr(A_TIMER, 32'd10);
        wr(A_COMPARE, 32'd20);
        edges_to_int = 0;
        for (int i = 0; i < 40 && !timer_int; i++) begin
            idle();
            edges_to_int++;
        end
        check("int_rise_edge", edges_to_int, 32'd10);
        repeat (5) idle();
        check("int_sticky", {31'h0, timer_int}, 32'h1);
        wr(A_COMPARE, 32'h8000_0000);
        check("int_clear", {31'h0, timer_int}, 32'h0);

        // Clear beats a coincident match.
        wr(A_COMPARE, 32'd200);
        wr(A_TIMER, 32'd200);
        wr(A_COMPARE, 32'd5000);
        check("int_clear_wins", {31'h0, timer_int}, 32'h0);

        // Wrap through zero.
        wr(A_TIMER, 32'hFFFF_FFFE);
        rd(A_TIMER);
        check("wrap_0", bus.rdata, 32'hFFFF_FFFE);
        rd(A_TIMER);
        check("wrap_1", bus.rdata, 32'hFFFF_FFFF);
        rd(A_TIMER);
        check("wrap_2", bus.rdata, 32'h0000_0000);

        // Back-to-back write/read on SCRATCH.
        for (int k = 1; k <= 16; k++) begin
            wr(A_SCRATCH, k);
            check("b2b_wr_old", bus.rdata, k - 1);
            rd(A_SCRATCH);
            check("b2b_rd_new", bus.rdata, k);
        end

        // Switch synchronizer latency.
        switch = 8'h3C;
        repeat (3) idle();
        switch = 8'hA5;
        rd(A_SWITCH);
        check("sw_rd1", bus.rdata, 32'h0000_003C);
        rd(A_SWITCH);
        check("sw_rd2", bus.rdata, 32'h0000_003C);
        rd(A_SWITCH);
        check("sw_rd3", bus.rdata, 32'h0000_00A5);
        wr(A_SWITCH, 32'h0000_0000);
        rd(A_SWITCH);
        check("sw_ro", bus.rdata, 32'h0000_00A5);

        // Reset in the middle of activity.
        wr(A_NUM, 32'h5555_AAAA);
        mid_cycle_reset();
        rd(A_COMPARE);
        check("compare_after_rst", bus.rdata, 32'hFFFF_FFFF);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a, d;
            logic [3:0]  we;
            logic        en;
            if ($urandom_range(0, 15) == 0) switch = 8'($urandom);
            a  = addr_tbl[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
            d  = $urandom;
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0, 1:    we = 4'h0;
                2:       we = 4'hF;
                default: we = 4'($urandom);
            endcase
            // Occasionally aim COMPARE just ahead of the counter so matches occur.
            if (en && we == 4'hF && a[15:0] == 16'hE004 && $urandom_range(0, 1) == 1)
                d = m_regs[16'hE000] + 32'($urandom_range(2, 12));
            cycle(en, we, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
